// File: rtl/ref_particle_scheduler_pkg.sv
// Shared types and helpers for the reference-particle scheduler.
//   state_e      : scheduler FSM states
//   RD_LATENCY   : cycles from ram_rden to valid ram_q_* (registered RAM read)
//   clamp_count  : limits a requested scan length to the RAM depth
package ref_sched_pkg;

    localparam int unsigned RD_LATENCY = 2;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait1,
        StWait2,
        StHold,
        StDone
    } state_e;

    function automatic int unsigned clamp_count(input int unsigned count,
                                                input int unsigned depth);
        return (count > depth) ? depth : count;
    endfunction

endpackage

// File: rtl/ref_particle_scheduler_if.sv
// Shared port to the three per-axis reference-position RAMs (x, y, z).
//   ram_address        : common address for all three RAMs
//   ram_rden, ram_wren : read / write enables (never both high)
//   ram_data_x/y/z     : write data
//   ram_q_x/y/z        : read data, valid RD_LATENCY cycles after ram_rden
// master: the scheduler driving the port; slave: the RAM side.
interface ref_particle_scheduler_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_rden;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_data_x;
    logic [DATA_WIDTH-1:0] ram_data_y;
    logic [DATA_WIDTH-1:0] ram_data_z;
    logic [DATA_WIDTH-1:0] ram_q_x;
    logic [DATA_WIDTH-1:0] ram_q_y;
    logic [DATA_WIDTH-1:0] ram_q_z;

    modport master (
        output ram_address, ram_rden, ram_wren, ram_data_x, ram_data_y, ram_data_z,
        input  ram_q_x, ram_q_y, ram_q_z
    );

    modport slave (
        input  ram_address, ram_rden, ram_wren, ram_data_x, ram_data_y, ram_data_z,
        output ram_q_x, ram_q_y, ram_q_z
    );

endinterface

// File: rtl/ref_particle_scheduler.sv
// Reference-particle scheduler: scans ref_count entries of the x/y/z reference RAMs, holding
// each captured reference on ref_* until the force pipeline consumes it. The position-update
// writer shares the RAM port; writes are granted outside the read window.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start, ref_count            : scan launch pulse and length (clamped to DEPTH)
//   ref_consumed                : pipeline done with held reference
//   wr_req, wr_addr, wr_x/y/z   : position-update write request; wr_ack = write performed
//   ram                         : shared RAM port (master side)
//   ref_valid, ref_id, ref_x/y/z, ref_last : held reference
//   busy, done                  : scan in progress / one-cycle completion pulse
module ref_particle_scheduler
    import ref_sched_pkg::*;
#(
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   ref_count,
    input  logic                  ref_consumed,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_x,
    input  logic [DATA_WIDTH-1:0] wr_y,
    input  logic [DATA_WIDTH-1:0] wr_z,
    output logic                  wr_ack,
    ref_particle_scheduler_if.master ram,
    output logic                  ref_valid,
    output logic [ADDR_WIDTH-1:0] ref_id,
    output logic [DATA_WIDTH-1:0] ref_x,
    output logic [DATA_WIDTH-1:0] ref_y,
    output logic [DATA_WIDTH-1:0] ref_z,
    output logic                  ref_last,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_clamped;
    // Write granted in ISSUE last cycle; forces the read out next, capping deferral at one.
    logic                  wr_granted_q;
    // Tracks the outstanding read so capture lines up with the RAM's registered output.
    logic [RD_LATENCY-1:0] rd_pipe_q;
    logic                  issue_write;
    logic                  wr_grant;

    assign count_clamped = (ADDR_WIDTH + 1)'(clamp_count(32'(ref_count), DEPTH));
    assign issue_write   = wr_req && !wr_granted_q;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            count_q      <= '0;
            wr_granted_q <= 1'b0;
            rd_pipe_q    <= '0;
            ref_valid    <= 1'b0;
            ref_id       <= '0;
            ref_x        <= '0;
            ref_y        <= '0;
            ref_z        <= '0;
            ref_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_granted_q <= (state_q == StIssue) && wr_grant;
            rd_pipe_q    <= (rd_pipe_q << 1) | RD_LATENCY'(ram.ram_rden);
            ref_valid    <= (state_d == StHold);
            busy         <= (state_d != StIdle);
            done         <= (state_d == StDone);

            if (state_q == StIdle && start) begin
                idx_q   <= '0;
                count_q <= count_clamped;
            end else if (state_q == StHold && ref_consumed && !ref_last) begin
                idx_q <= idx_q + 1'b1;
            end

            // Read data arrives at the end of WAIT2; this copy is authoritative while held.
            if (rd_pipe_q[RD_LATENCY-1]) begin
                ref_x    <= ram.ram_q_x;
                ref_y    <= ram.ram_q_y;
                ref_z    <= ram.ram_q_z;
                ref_id   <= idx_q;
                ref_last <= ({1'b0, idx_q} == count_q - (ADDR_WIDTH + 1)'(1));
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (count_clamped == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (!issue_write) begin
                    state_d = StWait1;
                end
            end
            StWait1: state_d = StWait2;
            StWait2: state_d = StHold;
            StHold: begin
                if (ref_consumed) begin
                    state_d = ref_last ? StDone : StIssue;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // RAM port arbitration and combinational outputs.
    always_comb begin
        wr_grant     = 1'b0;
        ram.ram_rden = 1'b0;
        unique case (state_q)
            StIdle, StHold, StDone: wr_grant = wr_req;
            StIssue: begin
                wr_grant     = issue_write;
                ram.ram_rden = !issue_write;
            end
            default: wr_grant = 1'b0;
        endcase
        ram.ram_wren    = wr_grant;
        ram.ram_address = wr_grant ? wr_addr : idx_q;
        ram.ram_data_x  = wr_x;
        ram.ram_data_y  = wr_y;
        ram.ram_data_z  = wr_z;
        wr_ack          = wr_grant;
    end

endmodule

// File: tb/tb_ref_particle_scheduler.sv
module tb_ref_particle_scheduler;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   ref_count;
    logic          ref_consumed;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_x, wr_y, wr_z;
    logic          wr_ack;
    logic          ref_valid;
    logic [AW-1:0] ref_id;
    logic [DW-1:0] ref_x, ref_y, ref_z;
    logic          ref_last;
    logic          busy;
    logic          done;

    int vectors;
    int miscompares;

    // Expected RAM contents as seen by the bench.
    logic [DW-1:0] sx [DEPTH];
    logic [DW-1:0] sy [DEPTH];
    logic [DW-1:0] sz [DEPTH];

    ref_particle_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

    ref_particle_scheduler #(
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ref_count   (ref_count),
        .ref_consumed(ref_consumed),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_z        (wr_z),
        .wr_ack      (wr_ack),
        .ram         (ram_bus),
        .ref_valid   (ref_valid),
        .ref_id      (ref_id),
        .ref_x       (ref_x),
        .ref_y       (ref_y),
        .ref_z       (ref_z),
        .ref_last    (ref_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Three single-port RAMs with 2-cycle registered read.
    logic [DW-1:0] mem_x [DEPTH];
    logic [DW-1:0] mem_y [DEPTH];
    logic [DW-1:0] mem_z [DEPTH];
    logic [DW-1:0] p1x, p1y, p1z, p2x, p2y, p2z;

    always @(posedge clk) begin
        if (ram_bus.ram_wren) begin
            mem_x[ram_bus.ram_address] <= ram_bus.ram_data_x;
            mem_y[ram_bus.ram_address] <= ram_bus.ram_data_y;
            mem_z[ram_bus.ram_address] <= ram_bus.ram_data_z;
        end
        if (ram_bus.ram_rden) begin
            p1x <= mem_x[ram_bus.ram_address];
            p1y <= mem_y[ram_bus.ram_address];
            p1z <= mem_z[ram_bus.ram_address];
        end
        p2x <= p1x;
        p2y <= p1y;
        p2z <= p1z;
    end

    assign ram_bus.ram_q_x = p2x;
    assign ram_bus.ram_q_y = p2y;
    assign ram_bus.ram_q_z = p2z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes one word through the DUT while idle; the grant must be immediate.
    task automatic load_word(input int a, input logic [DW-1:0] x, input logic [DW-1:0] y,
                             input logic [DW-1:0] z);
        wr_req  = 1'b1;
        wr_addr = AW'(a);
        wr_x    = x;
        wr_y    = y;
        wr_z    = z;
        #1;
        vectors++;
        if (wr_ack !== 1'b1 || ram_bus.ram_wren !== 1'b1 || ram_bus.ram_address !== AW'(a)) begin
            miscompares++;
            $display("FAIL idle_write addr=%0d: wr_ack=%b wren=%b address=%0d, required 1 1 %0d",
                     a, wr_ack, ram_bus.ram_wren, ram_bus.ram_address, a);
        end
        tick();
        wr_req = 1'b0;
        sx[a] = x;
        sy[a] = y;
        sz[a] = z;
    endtask

    // Full scan of n particles; each held reference must match the bench's RAM image.
    task automatic run_scan(input int n, input bit rnd);
        int            exp_n, t, dly;
        logic          exp_last;
        logic [DW-1:0] hx, nx;
        exp_n     = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        ref_count = (AW + 1)'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        t     = 1;
        for (int k = 0; k < exp_n; k++) begin
            while (ref_valid !== 1'b1 && t < 12) begin
                vectors++;
                if ((ram_bus.ram_rden & ram_bus.ram_wren) !== 1'b0 || done !== 1'b0 ||
                    busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL scan_wait k=%0d: rden=%b wren=%b done=%b busy=%b", k,
                             ram_bus.ram_rden, ram_bus.ram_wren, done, busy);
                end
                tick();
                t++;
            end
            vectors++;
            if (t !== 4) begin
                miscompares++;
                $display("FAIL scan_latency k=%0d: valid after %0d cycles, required 4", k, t);
            end
            vectors++;
            if (ref_id !== AW'(k) || ref_x !== sx[k] || ref_y !== sy[k] || ref_z !== sz[k]) begin
                miscompares++;
                $display("FAIL scan_data k=%0d: id=%0d x=%h y=%h z=%h, required %0d %h %h %h",
                         k, ref_id, ref_x, ref_y, ref_z, k, sx[k], sy[k], sz[k]);
            end
            exp_last = (k == exp_n - 1);
            vectors++;
            if (ref_last !== exp_last) begin
                miscompares++;
                $display("FAIL scan_last k=%0d: ref_last=%b, required %b", k, ref_last, exp_last);
            end
            hx  = sx[k];
            dly = rnd ? int'($urandom_range(0, 3)) : 2;
            repeat (dly) tick();
            if (rnd && $urandom_range(0, 1) == 1) begin
                nx      = $urandom;
                wr_req  = 1'b1;
                wr_addr = AW'(k);
                wr_x    = nx;
                wr_y    = sy[k];
                wr_z    = sz[k];
                #1;
                vectors++;
                if (wr_ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL hold_write_ack k=%0d: wr_ack=%b, required 1", k, wr_ack);
                end
                tick();
                wr_req = 1'b0;
                sx[k]  = nx;
            end
            vectors++;
            if (ref_valid !== 1'b1 || ref_x !== hx || ref_id !== AW'(k)) begin
                miscompares++;
                $display("FAIL scan_hold k=%0d: valid=%b x=%h id=%0d, required 1 %h %0d", k,
                         ref_valid, ref_x, ref_id, hx, k);
            end
            ref_consumed = 1'b1;
            tick();
            ref_consumed = 1'b0;
            t = 1;
            if (k == exp_n - 1) begin
                vectors++;
                if (done !== 1'b1 || busy !== 1'b1 || ref_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_done: done=%b busy=%b valid=%b, required 1 1 0", done,
                             busy, ref_valid);
                end
                tick();
                vectors++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_idle: done=%b busy=%b, required 0 0", done, busy);
                end
            end else begin
                vectors++;
                if (ref_valid !== 1'b0 || done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_release k=%0d: valid=%b done=%b, required 0 0", k,
                             ref_valid, done);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b0;
        ref_count    = '0;
        ref_consumed = 1'b0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_x         = '0;
        wr_y         = '0;
        wr_z         = '0;
        tick();
        tick();
        vectors++;
        if ({ref_valid, ref_last, busy, done, ram_bus.ram_rden, ram_bus.ram_wren, wr_ack} !== 7'b0
            || ref_id !== '0 || ref_x !== '0 || ref_y !== '0 || ref_z !== '0) begin
            miscompares++;
            $display("FAIL reset_values: valid=%b last=%b busy=%b done=%b rden=%b wren=%b id=%0d",
                     ref_valid, ref_last, busy, done, ram_bus.ram_rden, ram_bus.ram_wren, ref_id);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_scan3();
        for (int i = 0; i < 3; i++) begin
            load_word(i, DW'(10 + i), $urandom, $urandom);
        end
        run_scan(3, 1'b0);
    endtask

    task automatic test_count_zero();
        ref_count = '0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || ram_bus.ram_rden !== 1'b0 || ref_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_cycle1: done=%b busy=%b rden=%b valid=%b, required 1 1 0 0", done,
                     busy, ram_bus.ram_rden, ref_valid);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || ram_bus.ram_rden !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_cycle2: done=%b busy=%b rden=%b, required 0 0 0", done, busy,
                     ram_bus.ram_rden);
        end
    endtask

    task automatic test_contention();
        int            t;
        logic [DW-1:0] d;
        d         = $urandom;
        ref_count = (AW + 1)'(1);
        start     = 1'b1;
        tick();
        start   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = AW'(5);
        wr_x    = d;
        wr_y    = ~d;
        wr_z    = d ^ 32'h5a5a5a5a;
        #1;
        vectors++;
        if (wr_ack !== 1'b1 || ram_bus.ram_rden !== 1'b0 || ram_bus.ram_address !== AW'(5)) begin
            miscompares++;
            $display("FAIL contend_grant: wr_ack=%b rden=%b address=%0d, required 1 0 5", wr_ack,
                     ram_bus.ram_rden, ram_bus.ram_address);
        end
        tick();
        vectors++;
        if (wr_ack !== 1'b0 || ram_bus.ram_rden !== 1'b1 || ram_bus.ram_address !== AW'(0)) begin
            miscompares++;
            $display("FAIL contend_read: wr_ack=%b rden=%b address=%0d, required 0 1 0", wr_ack,
                     ram_bus.ram_rden, ram_bus.ram_address);
        end
        wr_req = 1'b0;
        sx[5] = d;
        sy[5] = ~d;
        sz[5] = d ^ 32'h5a5a5a5a;
        t = 2;
        while (ref_valid !== 1'b1 && t < 12) begin
            tick();
            t++;
        end
        vectors++;
        if (t !== 5 || ref_x !== sx[0]) begin
            miscompares++;
            $display("FAIL contend_latency: valid after %0d x=%h, required 5 %h", t, ref_x, sx[0]);
        end
        ref_consumed = 1'b1;
        tick();
        ref_consumed = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL contend_done: done=%b, required 1", done);
        end
        tick();
    endtask

    task automatic test_write_blocked();
        logic [DW-1:0] d;
        d         = $urandom;
        ref_count = (AW + 1)'(1);
        start     = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (ram_bus.ram_rden !== 1'b1 || ram_bus.ram_wren !== 1'b0) begin
            miscompares++;
            $display("FAIL blocked_issue: rden=%b wren=%b, required 1 0", ram_bus.ram_rden,
                     ram_bus.ram_wren);
        end
        tick();
        wr_req  = 1'b1;
        wr_addr = AW'(7);
        wr_x    = d;
        wr_y    = d + 1;
        wr_z    = d + 2;
        for (int c = 2; c <= 3; c++) begin
            #1;
            vectors++;
            if (wr_ack !== 1'b0 || ram_bus.ram_wren !== 1'b0 || ref_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL blocked_wait cycle=%0d: wr_ack=%b wren=%b valid=%b, required 0 0 0",
                         c, wr_ack, ram_bus.ram_wren, ref_valid);
            end
            tick();
        end
        vectors++;
        if (wr_ack !== 1'b1 || ref_valid !== 1'b1 || ram_bus.ram_rden !== 1'b0 ||
            ram_bus.ram_address !== AW'(7) || ref_x !== sx[0]) begin
            miscompares++;
            $display("FAIL blocked_hold: wr_ack=%b valid=%b rden=%b addr=%0d x=%h, req 1 1 0 7 %h",
                     wr_ack, ref_valid, ram_bus.ram_rden, ram_bus.ram_address, ref_x, sx[0]);
        end
        tick();
        wr_req = 1'b0;
        sx[7] = d;
        sy[7] = d + 1;
        sz[7] = d + 2;
        ref_consumed = 1'b1;
        tick();
        ref_consumed = 1'b0;
        tick();
    endtask

    task automatic test_held_write();
        int            t;
        logic [DW-1:0] old;
        ref_count = (AW + 1)'(3);
        start     = 1'b1;
        tick();
        start = 1'b0;
        t     = 1;
        for (int k = 0; k < 3; k++) begin
            while (ref_valid !== 1'b1 && t < 12) begin
                tick();
                t++;
            end
            vectors++;
            if (ref_valid !== 1'b1 || ref_id !== AW'(k)) begin
                miscompares++;
                $display("FAIL held_seq k=%0d: valid=%b id=%0d, required 1 %0d", k, ref_valid,
                         ref_id, k);
            end
            if (k == 1) begin
                old     = sx[1];
                wr_req  = 1'b1;
                wr_addr = AW'(1);
                wr_x    = 32'd99;
                wr_y    = sy[1];
                wr_z    = sz[1];
                #1;
                vectors++;
                if (wr_ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL held_wr_ack: wr_ack=%b, required 1", wr_ack);
                end
                tick();
                wr_req = 1'b0;
                vectors++;
                if (ref_x !== old || ref_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL held_copy: x=%h valid=%b, required %h 1", ref_x, ref_valid, old);
                end
                sx[1] = 32'd99;
            end
            ref_consumed = 1'b1;
            tick();
            ref_consumed = 1'b0;
            t = 1;
        end
        tick();
        run_scan(2, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        int t;
        ref_count = (AW + 1)'(3);
        start     = 1'b1;
        tick();
        start = 1'b0;
        t     = 1;
        while (ref_valid !== 1'b1 && t < 12) begin
            tick();
            t++;
        end
        vectors++;
        if (ref_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_setup: valid=%b, required 1", ref_valid);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({ref_valid, ref_last, busy, done, ram_bus.ram_rden, ram_bus.ram_wren, wr_ack} !== 7'b0
            || ref_id !== '0 || ref_x !== '0 || ref_y !== '0 || ref_z !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_hold: valid=%b busy=%b done=%b rden=%b id=%0d x=%h", ref_valid,
                     busy, done, ram_bus.ram_rden, ref_id, ref_x);
        end
        tick();
        rst = 1'b0;
        repeat (4) begin
            tick();
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || ref_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_after: done=%b busy=%b valid=%b, required 0 0 0", done, busy,
                         ref_valid);
            end
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < int'(DEPTH); i++) begin
            load_word(i, $urandom, $urandom, $urandom);
        end
        run_scan(int'($urandom_range(513, 1023)), 1'b0);
    endtask

    task automatic test_random_scans();
        repeat (6) begin
            run_scan(int'($urandom_range(1, 10)), 1'b1);
        end
        run_scan(10, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_scan3();
        test_count_zero();
        test_contention();
        test_write_blocked();
        test_held_write();
        test_reset_mid_hold();
        test_clamp();
        test_random_scans();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
